// File: rtl/exmem_pipe_reg.sv
// EX->MEM pipeline stage register with valid/ready handshake and a two-entry
// skid buffer (main + skid), synchronous flush, bubble masking of the control
// bundle and a forwarding tap for the hazard unit.
// Optional feature macro: EXMEM_STATS_EN adds a saturating 16-bit stall counter
// (stall_cnt) that counts cycles with out_valid & ~out_ready.
module exmem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [REG_W-1:0]  in_wreg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_wdata,
    output logic [REG_W-1:0]  out_wreg,
    output logic              fwd_en,
    output logic [REG_W-1:0]  fwd_reg,
`ifdef EXMEM_STATS_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [DATA_W-1:0] fwd_data
);

    localparam int PW = CTRL_W + 2 * DATA_W + REG_W;

    // Encoding is {skid_v, main_v}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic [PW-1:0]   in_pl;
    logic            main_v, skid_v;
    logic            accept, take;
    logic [CTRL_W-1:0] main_ctrl;

    assign in_pl  = {in_ctrl, in_alu, in_wdata, in_wreg};
    assign main_v = state_q[0];
    assign skid_v = state_q[1];

    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    assign {main_ctrl, out_alu, out_wdata, out_wreg} = main_q;

    // Bubble masking: control is zeroed whenever the main entry is empty.
    assign out_ctrl = main_v ? main_ctrl : '0;
    assign fwd_en   = out_valid & out_ctrl[0] & ~out_ctrl[1];
    assign fwd_reg  = out_wreg;
    assign fwd_data = out_alu;

    // Next-state and entry-load logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_pl;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_d = in_pl;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_pl;
                    end else if (take) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (take) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef EXMEM_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt = stall_cnt_q;

    // Saturating count of cycles where MEM holds off a valid entry.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Scoreboard bench for exmem_pipe_reg: driver pushes expected entries on
// accepted offers, a negedge monitor pops and compares on every take.
module tb_exmem_pipe_reg;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  wreg;
    } pl_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_ctrl = '0;
    logic [31:0] in_alu = '0;
    logic [31:0] in_wdata = '0;
    logic [4:0]  in_wreg = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_ctrl;
    logic [31:0] out_alu;
    logic [31:0] out_wdata;
    logic [4:0]  out_wreg;
    logic        fwd_en;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
`ifdef EXMEM_STATS_EN
    logic [15:0] stall_cnt;
`endif

    pl_t exp_q[$];
    pl_t sb_e;
    int  checks = 0;
    int  errors = 0;

    exmem_pipe_reg #(.DATA_W(32), .REG_W(5), .CTRL_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_alu    (in_alu),
        .in_wdata  (in_wdata),
        .in_wreg   (in_wreg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_alu   (out_alu),
        .out_wdata (out_wdata),
        .out_wreg  (out_wreg),
        .fwd_en    (fwd_en),
        .fwd_reg   (fwd_reg),
`ifdef EXMEM_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] w, input logic [4:0] r, input logic exp_acc);
        in_valid = v;
        in_ctrl  = c;
        in_alu   = a;
        in_wdata = w;
        in_wreg  = r;
        if (exp_acc) exp_q.push_back('{ctrl: c, alu: a, wdata: w, wreg: r});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every take must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=alu %0h required=no entry", out_alu);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_ctrl", {28'd0, out_ctrl}, {28'd0, sb_e.ctrl});
                chk("sb_alu", out_alu, sb_e.alu);
                chk("sb_wdata", out_wdata, sb_e.wdata);
                chk("sb_wreg", {27'd0, out_wreg}, {27'd0, sb_e.wreg});
            end
        end
    end

    initial begin
        // Reset values while reset is held.
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_ctrl", {28'd0, out_ctrl}, 32'd0);
        chk("rst_fwd_en", {31'd0, fwd_en}, 32'd0);
        chk("rst_alu", out_alu, 32'd0);
        chk("rst_wreg", {27'd0, out_wreg}, 32'd0);
        step();
        reset = 1'b0;

        // Streaming: 8 back-to-back accepts, outputs one cycle late.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(1'b1, 4'b0001, 32'(i), 32'(i) << 4, 5'(i), 1'b1);
            @(negedge clk);
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
            if (i > 1) begin
                chk("stream_valid", {31'd0, out_valid}, 32'd1);
                chk("stream_lat", out_alu, 32'(i - 1));
            end
            step();
        end
        send(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("stream_last", out_alu, 32'd8);
        step();
        @(negedge clk);
        chk("stream_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("stream_idle_ctrl", {28'd0, out_ctrl}, 32'd0);
        step();

        // Skid: A held, B goes to skid, C refused, then A, B drain in order.
        out_ready = 1'b0;
        send(1'b1, 4'b0001, 32'hA, 32'hA0, 5'd10, 1'b1);
        @(negedge clk);
        chk("skid_ready_a", {31'd0, in_ready}, 32'd1);
        step();
        send(1'b1, 4'b0011, 32'hB, 32'hB0, 5'd11, 1'b1);
        @(negedge clk);
        chk("skid_ready_b", {31'd0, in_ready}, 32'd1);
        chk("skid_hold_a", out_alu, 32'hA);
        step();
        send(1'b1, 4'b0001, 32'hC, 32'hC0, 5'd12, 1'b0);
        @(negedge clk);
        chk("skid_full_ready", {31'd0, in_ready}, 32'd0);
        chk("skid_full_valid", {31'd0, out_valid}, 32'd1);
        chk("skid_full_alu", out_alu, 32'hA);
        step();
        send(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("skid_take_ready", {31'd0, in_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("skid_reopen", {31'd0, in_ready}, 32'd1);
        chk("skid_b_alu", out_alu, 32'hB);
        chk("skid_b_nofwd", {31'd0, fwd_en}, 32'd0);
        step();
        @(negedge clk);
        chk("skid_empty", {31'd0, out_valid}, 32'd0);
        step();

        // Flush in TWO with an offered entry.
        out_ready = 1'b0;
        send(1'b1, 4'b0001, 32'hD, 32'hD0, 5'd13, 1'b1);
        step();
        send(1'b1, 4'b0001, 32'hE, 32'hE0, 5'd14, 1'b1);
        step();
        send(1'b1, 4'b0001, 32'hF, 32'hF0, 5'd15, 1'b0);
        flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("flush_pre_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        send(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_ctrl", {28'd0, out_ctrl}, 32'd0);
        step();

        // Flush with a concurrent accept from EMPTY drops the entry.
        send(1'b1, 4'b0001, 32'h77, 32'h70, 5'd7, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        send(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("flush_drop", {31'd0, out_valid}, 32'd0);
        step();

        // Bubble and forward.
        send(1'b1, 4'b0001, 32'h1234, 32'h55, 5'd9, 1'b1);
        step();
        send(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("fwd_en", {31'd0, fwd_en}, 32'd1);
        chk("fwd_reg", {27'd0, fwd_reg}, 32'd9);
        chk("fwd_data", fwd_data, 32'h1234);
        step();
        @(negedge clk);
        chk("bubble_ctrl", {28'd0, out_ctrl}, 32'd0);
        chk("bubble_fwd_en", {31'd0, fwd_en}, 32'd0);
        chk("bubble_alu_hold", out_alu, 32'h1234);
        step();

        // Asynchronous reset in the middle of a cycle with an entry held.
        out_ready = 1'b0;
        send(1'b1, 4'b0101, 32'hDEAD, 32'hBEEF, 5'd3, 1'b1);
        step();
        send(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_ctrl", {28'd0, out_ctrl}, 32'd0);
        chk("arst_alu", out_alu, 32'd0);
        step();
        reset = 1'b0;

`ifdef EXMEM_STATS_EN
        // Stall counter: 5 stalled cycles, then saturation, flush keeps it.
        @(negedge clk);
        chk("stats_reset", {16'd0, stall_cnt}, 32'd0);
        step();
        send(1'b1, 4'b0001, 32'h5, 32'h50, 5'd5, 1'b1);
        step();
        send(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (5) step();
        @(negedge clk);
        chk("stats_five", {16'd0, stall_cnt}, 32'd5);
        repeat (65535) step();
        @(negedge clk);
        chk("stats_sat", {16'd0, stall_cnt}, 32'hFFFF);
        step();
        @(negedge clk);
        chk("stats_sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
        flush = 1'b1;
        exp_q.delete();
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("stats_flush_keep", {16'd0, stall_cnt}, 32'hFFFF);
        step();
`endif

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
